// File: rtl/serial_pkg.sv
// Shared types for the bit-serial add host.
// FSM encoding and default operand width.
package serial_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_shreg.sv
// Right shift register with parallel load.
// Serial data enters at the MSB and leaves from bit 0.
module serial_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic             o_sout,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[WIDTH-1:1]};
    end
  end

  assign o_sout = r_q[0];
  assign o_q    = r_q;

endmodule

// File: rtl/serial_add_host.sv
// Feeds parallel operands LSB-first to an external
// serial adder and reassembles the parallel result.
module serial_add_host
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_first,
  input  logic             ser_sum,
  input  logic             ser_cy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_a_bit;
  logic             w_b_bit;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_a_unused;
  logic [WIDTH-1:0] w_b_unused;
  logic             w_res_unused;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_shift  = (r_state == SHIFT);
  assign w_last   = w_shift && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // On the last bit the operand LSBs hold the captured MSBs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_cout <= ser_cy;
      r_ovf  <= (w_a_bit == w_b_bit)
             && (ser_sum != w_a_bit);
    end
  end

  serial_shreg #(.WIDTH(WIDTH)) u_opa (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_d     (a),
    .i_shift (w_shift),
    .i_sin   (1'b0),
    .o_sout  (w_a_bit),
    .o_q     (w_a_unused)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_opb (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_d     (b),
    .i_shift (w_shift),
    .i_sin   (1'b0),
    .o_sout  (w_b_bit),
    .o_q     (w_b_unused)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_res (
    .clk     (clk),
    .rst     (rst),
    .i_load  (1'b0),
    .i_d     ('0),
    .i_shift (w_shift),
    .i_sin   (ser_sum),
    .o_sout  (w_res_unused),
    .o_q     (w_res)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign ser_valid = w_shift;
  assign ser_first = w_shift && (r_cnt == '0);
  assign ser_a     = w_shift && w_a_bit;
  assign ser_b     = w_shift && w_b_bit;
  assign sum       = w_res;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_add_host.sv
// Scoreboard bench for serial_add_host, 4- and 8-bit
// instances, each paired with a behavioural serial adder.
module tb_serial_add_host;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q4[$];
  exp_t q8[$];

  logic       iv4, ir4, sa4, sb4, sv4, sf4;
  logic       ss4, sc4, ov4, or4, co4, of4;
  logic [3:0] a4, b4, s4;
  logic       c4, ci4;

  logic       iv8, ir8, sa8, sb8, sv8, sf8;
  logic       ss8, sc8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic       c8, ci8;

  serial_add_host #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .ser_a     (sa4),
    .ser_b     (sb4),
    .ser_valid (sv4),
    .ser_first (sf4),
    .ser_sum   (ss4),
    .ser_cy    (sc4),
    .out_valid (ov4),
    .out_ready (or4),
    .sum       (s4),
    .cout      (co4),
    .ovf       (of4)
  );

  serial_add_host #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .ser_a     (sa8),
    .ser_b     (sb8),
    .ser_valid (sv8),
    .ser_first (sf8),
    .ser_sum   (ss8),
    .ser_cy    (sc8),
    .out_valid (ov8),
    .out_ready (or8),
    .sum       (s8),
    .cout      (co8),
    .ovf       (of8)
  );

  initial c4 = 1'b0;
  initial c8 = 1'b0;
  assign ci4 = sf4 ? 1'b0 : c4;
  assign ss4 = sa4 ^ sb4 ^ ci4;
  assign sc4 = (sa4 & sb4) | (ci4 & (sa4 ^ sb4));
  assign ci8 = sf8 ? 1'b0 : c8;
  assign ss8 = sa8 ^ sb8 ^ ci8;
  assign sc8 = (sa8 & sb8) | (ci8 & (sa8 ^ sb8));

  always @(posedge clk) begin
    if (sv4) c4 <= sc4;
    if (sv8) c8 <= sc8;
    cyc <= cyc + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  initial begin : mon4
    int   nf, nv;
    logic pov;
    exp_t e;
    nf = 0; nv = 0; pov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nf = 0; nv = 0; pov = 1'b0;
      end else begin
        nf += int'(sf4);
        nv += int'(sv4);
        if (ov4 && !pov) begin
          if (q4.size() == 0) chk("unexp4", 1, 0);
          else chk("lat4", cyc - q4[0].acc, 5);
        end
        if (ov4 && or4 && q4.size() > 0) begin
          e = q4.pop_front();
          chk("sum4", {28'd0, s4}, {24'd0, e.s});
          chk("cout4", {31'd0, co4}, {31'd0, e.c});
          chk("ovf4", {31'd0, of4}, {31'd0, e.o});
          chk("first4", nf, 1);
          chk("nbits4", nv, 4);
          nf = 0; nv = 0;
        end
        pov = ov4;
      end
    end
  end

  initial begin : mon8
    int   nf, nv;
    logic pov;
    exp_t e;
    nf = 0; nv = 0; pov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nf = 0; nv = 0; pov = 1'b0;
      end else begin
        nf += int'(sf8);
        nv += int'(sv8);
        if (ov8 && !pov) begin
          if (q8.size() == 0) chk("unexp8", 1, 0);
          else chk("lat8", cyc - q8[0].acc, 9);
        end
        if (ov8 && or8 && q8.size() > 0) begin
          e = q8.pop_front();
          chk("sum8", {24'd0, s8}, {24'd0, e.s});
          chk("cout8", {31'd0, co8}, {31'd0, e.c});
          chk("ovf8", {31'd0, of8}, {31'd0, e.o});
          chk("first8", nf, 1);
          chk("nbits8", nv, 8);
          nf = 0; nv = 0;
        end
        pov = ov8;
      end
    end
  end

  task automatic send4(input logic [3:0] a,
                       input logic [3:0] b,
                       input logic [3:0] s,
                       input logic c, input logic o);
    int t = 0;
    while (!ir4 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!ir4) begin
      chk("rdy4", {31'd0, ir4}, 1);
      return;
    end
    iv4 = 1'b1; a4 = a; b4 = b;
    q4.push_back('{{4'd0, s}, c, o, cyc});
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] s,
                       input logic c, input logic o);
    int t = 0;
    while (!ir8 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!ir8) begin
      chk("rdy8", {31'd0, ir8}, 1);
      return;
    end
    iv8 = 1'b1; a8 = a; b8 = b;
    q8.push_back('{s, c, o, cyc});
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q4.size() + q8.size()) != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if ((q4.size() + q8.size()) != 0) begin
      chk("drain", q4.size() + q8.size(), 0);
      q4.delete();
      q8.delete();
    end
  endtask

  initial begin
    int t;
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, ir4}, 1);
    chk("rst_ovalid", {31'd0, ov4}, 0);
    chk("rst_sum", {28'd0, s4}, 0);
    chk("rst_cout", {31'd0, co4}, 0);
    chk("rst_ovf", {31'd0, of4}, 0);
    chk("rst_serv", {31'd0, sv4}, 0);
    chk("rst_ready8", {31'd0, ir8}, 1);

    send4(4'h3, 4'h5, 4'h8, 1'b0, 1'b1);
    send4(4'hF, 4'h1, 4'h0, 1'b1, 1'b0);
    send4(4'h7, 4'h7, 4'hE, 1'b0, 1'b1);
    send4(4'h9, 4'hA, 4'h3, 1'b1, 1'b1);
    drain();

    or4 = 1'b0;
    send4(4'h6, 4'h1, 4'h7, 1'b0, 1'b0);
    t = 0;
    while (!ov4 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("stall_reach", {31'd0, ov4}, 1);
    for (int i = 0; i < 10; i++) begin
      iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
      @(posedge clk); #1;
      chk("stall_ov", {31'd0, ov4}, 1);
      chk("stall_sum", {28'd0, s4}, 32'h7);
      chk("stall_rdy", {31'd0, ir4}, 0);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    drain();
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_serv", {31'd0, sv4}, 0);
      chk("idle_ov", {31'd0, ov4}, 0);
      chk("hold_sum", {28'd0, s4}, 32'h7);
    end

    a4 = 4'h5; b4 = 4'h6; iv4 = 1'b1;
    @(posedge clk); #1 iv4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_serv", {31'd0, sv4}, 1);
    rst = 1'b0;
    #1;
    chk("ar_serv", {31'd0, sv4}, 0);
    chk("ar_first", {31'd0, sf4}, 0);
    chk("ar_sera", {31'd0, sa4}, 0);
    chk("ar_serb", {31'd0, sb4}, 0);
    chk("ar_ov", {31'd0, ov4}, 0);
    chk("ar_sum", {28'd0, s4}, 0);
    chk("ar_cout", {31'd0, co4}, 0);
    chk("ar_ovf", {31'd0, of4}, 0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("ar_ready", {31'd0, ir4}, 1);
    send4(4'h2, 4'h2, 4'h4, 1'b0, 1'b0);
    drain();

    send8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    send8(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_host.md
SERIAL_ADD_HOST -- requirements
Module: serial_add_host

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  parallel operands a,b present.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: a  input  WIDTH  operand A, unsigned/two's complement.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: ser_a  output  1  serial operand A bit to adder, LSB-first.
REQ-009 SHALL have port: ser_b  output  1  serial operand B bit to adder, LSB-first.
REQ-010 SHALL have port: ser_valid  output  1  ser_a/ser_b carry a live bit.
REQ-011 SHALL have port: ser_first  output  1  current bit is bit 0; adder clears its stored carry.
REQ-012 SHALL have port: ser_sum  input  1  adder combinational sum for current bit.
REQ-013 SHALL have port: ser_cy  input  1  adder combinational carry-out for current bit.
REQ-014 SHALL have port: out_valid  output  1  result valid, held until accepted.
REQ-015 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port: sum  output  WIDTH  parallel sum.
REQ-017 SHALL have port: cout  output  1  unsigned carry-out of bit WIDTH-1.
REQ-018 SHALL have port: ovf  output  1  signed overflow.

Function
REQ-019 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-020 SHALL drive in_ready=1 only in IDLE.
REQ-021 IDLE: on in_valid&&in_ready, SHALL capture a,b into shift regs, clear bit counter, go SHIFT.
REQ-022 SHIFT cycle k (k=0..WIDTH-1): SHALL drive ser_a=A[k], ser_b=B[k], ser_valid=1, ser_first=(k==0).
REQ-023 SHIFT: each rising edge SHALL shift operand regs right by one and shift ser_sum into result reg MSB (shift right), so sum[k]=ser_sum sampled in cycle k.
REQ-024 SHIFT at k=WIDTH-1: SHALL register cout=ser_cy, go DONE.
REQ-025 SHALL compute ovf at the transition to DONE: (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]), using captured operand MSBs.
REQ-026 DONE: SHALL hold out_valid=1 with sum/cout/ovf stable until out_ready=1; on that edge go IDLE.
REQ-027 Latency: out_valid SHALL assert WIDTH+1 cycles after the accepting edge; throughput one op per WIDTH+2 cycles with out_ready tied high.
REQ-028 Outside SHIFT: ser_a, ser_b, ser_valid, ser_first SHALL be 0.
REQ-029 in_valid during SHIFT/DONE SHALL be ignored; operands not sampled.
REQ-030 out_ready while not DONE SHALL have no effect.
REQ-031 sum/cout/ovf SHALL keep last result after leaving DONE until next result overwrites them.

Reset
REQ-032 rst low SHALL force IDLE, counter 0, operand/result regs 0, cout=0, ovf=0, out_valid=0, all ser_* outputs 0; in_ready=1 after release.
REQ-033 rst asserted mid-SHIFT or in DONE SHALL abort the operation; no partial result SHALL be presented.

Structure
REQ-034 Package serial_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and default WIDTH constant.
REQ-035 Counter width SHALL be $clog2(WIDTH).
REQ-036 One sub-module serial_shreg (WIDTH-bit right shift reg, parallel load, serial in/out) SHALL be instantiated for operands and for result.

Verification (bench uses behavioural serial adder: carry reg cleared on ser_first, sum/cy combinational)
REQ-037 a=4'h3, b=4'h5 -> out_valid 5 cycles after accept, sum=4'h8, cout=0, ovf=1.
REQ-038 a=4'hF, b=4'h1 -> sum=4'h0, cout=1, ovf=0; ser_first high exactly one cycle per op.
REQ-039 Back-to-back ops 4'h7+4'h7 then 4'h9+4'hA with out_ready high -> 4'hE (ovf=1) then 4'h3 (cout=1, ovf=1); no carry leaks between ops.
REQ-040 out_ready low 10 cycles in DONE -> out_valid/sum stable, in_ready=0, new in_valid ignored.
REQ-041 rst pulsed at SHIFT k=2 -> all outputs 0, IDLE; next op 4'h2+4'h2 yields 4'h4.
REQ-042 WIDTH=8: 8'hFF+8'h01 -> sum=8'h00, cout=1, latency 9 cycles.
